// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//               synchronizes the active-low rows and debounces both the press
//               and the release of the tracked key. Each accepted press
//               updates the hex digit s and raises a one-cycle en strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] s,
    output logic       en
);

    localparam int c_SCAN_W = $clog2(SCAN_DIV);
    localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_ONE  = c_SCAN_W'(1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);

    localparam logic [1:0] c_SCAN     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [1:0] c_RELEASE  = 2'd3;

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [1:0]          r_state;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [1:0]          r_col;
    logic [1:0]          r_row;
    logic [3:0]          r_s;
    logic                r_en;

    logic [1:0]          w_low_row;
    logic [3:0]          w_digit;
    logic                w_key_high;

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= rows;
            r_sync2 <= r_sync1;
        end
    end

    // Lowest-index active row wins when several rows are low together.
    always_comb begin
        w_low_row = 2'd0;
        if (!r_sync2[0]) begin
            w_low_row = 2'd0;
        end else if (!r_sync2[1]) begin
            w_low_row = 2'd1;
        end else if (!r_sync2[2]) begin
            w_low_row = 2'd2;
        end else begin
            w_low_row = 2'd3;
        end
    end

    // Key map lookup for the latched row and the held column.
    always_comb begin
        w_digit = 4'h0;
        case ({r_row, r_col})
            4'b0000: w_digit = 4'h1;
            4'b0001: w_digit = 4'h2;
            4'b0010: w_digit = 4'h3;
            4'b0011: w_digit = 4'hA;
            4'b0100: w_digit = 4'h4;
            4'b0101: w_digit = 4'h5;
            4'b0110: w_digit = 4'h6;
            4'b0111: w_digit = 4'hB;
            4'b1000: w_digit = 4'h7;
            4'b1001: w_digit = 4'h8;
            4'b1010: w_digit = 4'h9;
            4'b1011: w_digit = 4'hC;
            4'b1100: w_digit = 4'hE;
            4'b1101: w_digit = 4'h0;
            4'b1110: w_digit = 4'hF;
            default: w_digit = 4'hD;
        endcase
    end

    // Only the latched row of the tracked key matters once a key is detected.
    assign w_key_high = r_sync2[r_row];

    // Exactly one column driven low, selected by the current column index.
    always_comb begin
        cols        = 4'b1111;
        cols[r_col] = 1'b0;
    end

    // Scan / debounce / hold / release sequencing of the tracked key.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_SCAN;
            r_scan_cnt <= '0;
            r_deb_cnt  <= '0;
            r_col      <= 2'd0;
            r_row      <= 2'd0;
            r_s        <= 4'h0;
            r_en       <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                c_SCAN: begin
                    // Rows are only trusted at the end of the column slot,
                    // after the drive change has propagated through the sync.
                    if (r_scan_cnt == c_SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (r_sync2 != 4'b1111) begin
                            r_row     <= w_low_row;
                            r_deb_cnt <= '0;
                            r_state   <= c_DEBOUNCE;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + c_SCAN_ONE;
                    end
                end
                c_DEBOUNCE: begin
                    if (!w_key_high) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            r_state <= c_HELD;
                            r_s     <= w_digit;
                            r_en    <= 1'b1;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
                        end
                    end else begin
                        // Bounce: retry on the same column from a fresh slot.
                        r_state    <= c_SCAN;
                        r_scan_cnt <= '0;
                    end
                end
                c_HELD: begin
                    if (w_key_high) begin
                        r_state   <= c_RELEASE;
                        r_deb_cnt <= '0;
                    end
                end
                c_RELEASE: begin
                    if (w_key_high) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            r_state    <= c_SCAN;
                            r_scan_cnt <= '0;
                            r_col      <= r_col + 2'd1;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
                        end
                    end else begin
                        // Release bounce: key is still down, no new strobe.
                        r_state <= c_HELD;
                    end
                end
                default: begin
                    r_state <= c_SCAN;
                end
            endcase
        end
    end

    assign s  = r_s;
    assign en = r_en;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A physical keypad
//               model produces the rows from the driven columns; a run-length
//               reference model predicts cols, s and en every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DEB = 8;

    localparam int M_IDLE    = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_HOLD    = 2;
    localparam int M_REL     = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  s;
    logic        en;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rows  (rows),
        .cols  (cols),
        .s     (s),
        .en    (en)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when driven.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    typedef struct packed {
        int         mode;
        int         col;
        int         tick;
        int         run;
        int         key_row;
        logic [3:0] s;
        logic       en;
        logic [3:0] s1;
        logic [3:0] s2;
    } mstate_t;

    mstate_t m;

    function automatic logic [3:0] key_digit(input int k);
        logic [63:0] tbl;
        tbl = 64'hDF0E_C987_B654_A321;
        return tbl[k*4 +: 4];
    endfunction

    function automatic logic [3:0] col_drive(input int col);
        logic [3:0] v;
        v = 4'b1111;
        v[col] = 1'b0;
        return v;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t n;
        n = '0;
        n.mode = M_IDLE;
        n.s1 = 4'hF;
        n.s2 = 4'hF;
        return n;
    endfunction

    // Run-length reference: counts stable samples of the synchronized rows.
    function automatic mstate_t model_step(input mstate_t c, input logic [3:0] rin);
        mstate_t    n;
        logic [3:0] rs;
        int         low;
        n = c;
        n.en = 1'b0;
        n.s1 = rin;
        n.s2 = c.s1;
        rs = c.s2;
        low = 0;
        for (int r = 3; r >= 0; r--) if (!rs[r]) low = r;
        case (c.mode)
            M_IDLE: begin
                if (c.tick == SD - 1) begin
                    n.tick = 0;
                    if (rs != 4'hF) begin
                        n.mode = M_CONFIRM;
                        n.key_row = low;
                        n.run = 0;
                    end else begin
                        n.col = (c.col + 1) % 4;
                    end
                end else begin
                    n.tick = c.tick + 1;
                end
            end
            M_CONFIRM: begin
                if (!rs[c.key_row]) begin
                    n.run = c.run + 1;
                    if (n.run == DEB) begin
                        n.mode = M_HOLD;
                        n.s = key_digit(c.key_row * 4 + c.col);
                        n.en = 1'b1;
                    end
                end else begin
                    n.mode = M_IDLE;
                    n.tick = 0;
                end
            end
            M_HOLD: begin
                if (rs[c.key_row]) begin
                    n.mode = M_REL;
                    n.run = 1;
                end
            end
            default: begin
                if (rs[c.key_row]) begin
                    n.run = c.run + 1;
                    if (n.run == DEB + 1) begin
                        n.mode = M_IDLE;
                        n.col = (c.col + 1) % 4;
                        n.tick = 0;
                    end
                end else begin
                    n.mode = M_HOLD;
                end
            end
        endcase
        return n;
    endfunction

    // Reference model advances on the same edges the DUT samples.
    always @(posedge clk) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, rows);
    end

    task automatic test_reset();
        reset = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cols !== 4'b1110) begin n_errors++; $display("FAIL reset_cols: got %b expected 1110", cols); end
        n_checks++;
        if (s !== 4'h0) begin n_errors++; $display("FAIL reset_s: got %h expected 0", s); end
        n_checks++;
        if (en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %b expected 0", en); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (cols !== col_drive((i / SD) % 4)) begin
                n_errors++;
                $display("FAIL idle_cols cycle %0d: got %b expected %b", i, cols, col_drive((i / SD) % 4));
            end
            n_checks++;
            if (en !== 1'b0 || s !== 4'h0) begin
                n_errors++;
                $display("FAIL idle_out cycle %0d: got en=%b s=%h expected en=0 s=0", i, en, s);
            end
        end
    endtask

    task automatic test_press_5();
        int en_cnt = 0;
        int first_chg = 0;
        logic [3:0] new_col = 4'h0;
        pressed[5] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if ({cols, s, en} !== {col_drive(m.col), m.s, m.en}) begin
                n_errors++;
                $display("FAIL press5_model: got cols=%b s=%h en=%b expected cols=%b s=%h en=%b", cols, s, en, col_drive(m.col), m.s, m.en);
            end
            if (en) en_cnt++;
            if (en_cnt > 0) begin
                n_checks++;
                if (cols !== 4'b1101) begin n_errors++; $display("FAIL press5_frozen: got cols=%b expected 1101", cols); end
            end
        end
        n_checks++;
        if (en_cnt != 1) begin n_errors++; $display("FAIL press5_en_count: got %0d expected 1", en_cnt); end
        n_checks++;
        if (s !== 4'h5) begin n_errors++; $display("FAIL press5_s: got %h expected 5", s); end
        pressed[5] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (en) en_cnt++;
            if (first_chg == 0 && cols !== 4'b1101) begin first_chg = i; new_col = cols; end
        end
        n_checks++;
        if (en_cnt != 1) begin n_errors++; $display("FAIL press5_release_en: got %0d pulses expected 1", en_cnt); end
        n_checks++;
        if (first_chg != 3 + DEB || new_col !== 4'b1011) begin
            n_errors++;
            $display("FAIL press5_resume: got cols=%b after %0d cycles expected 1011 after %0d", new_col, first_chg, 3 + DEB);
        end
    endtask

    task automatic test_bounce_9();
        int en_cnt = 0;
        int lat = 0;
        bit seen = 0;
        pressed[10] = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m.mode == M_CONFIRM) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL bounce9_detect: got no detection expected one within 40 cycles"); end
        for (int i = 1; i <= 80; i++) begin
            if (i == 2) pressed[10] = 1'b0;
            if (i == 3) pressed[10] = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({cols, s, en} !== {col_drive(m.col), m.s, m.en}) begin
                n_errors++;
                $display("FAIL bounce9_model: got cols=%b s=%h en=%b expected cols=%b s=%h en=%b", cols, s, en, col_drive(m.col), m.s, m.en);
            end
            if (en) begin en_cnt++; if (lat == 0) lat = i; end
        end
        n_checks++;
        if (en_cnt != 1 || s !== 4'h9) begin n_errors++; $display("FAIL bounce9_result: got %0d pulses s=%h expected 1 pulse s=9", en_cnt, s); end
        n_checks++;
        if (lat <= DEB + 2) begin n_errors++; $display("FAIL bounce9_abort: got en after %0d cycles expected more than %0d", lat, DEB + 2); end
        pressed[10] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_release_bounce_0();
        int en_cnt = 0;
        int first_chg = 0;
        bit seen = 0;
        pressed[13] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (en) seen = 1;
        end
        n_checks++;
        if (!seen || s !== 4'h0) begin n_errors++; $display("FAIL rel0_accept: got seen=%0d s=%h expected en with s=0", seen, s); end
        repeat (5) @(negedge clk);
        pressed[13] = 1'b0;
        repeat (4) @(negedge clk);
        pressed[13] = 1'b1;
        repeat (2) @(negedge clk);
        pressed[13] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_checks++;
            if ({cols, s, en} !== {col_drive(m.col), m.s, m.en}) begin
                n_errors++;
                $display("FAIL rel0_model: got cols=%b s=%h en=%b expected cols=%b s=%h en=%b", cols, s, en, col_drive(m.col), m.s, m.en);
            end
            if (en) en_cnt++;
            if (first_chg == 0 && cols !== 4'b1101) first_chg = i;
        end
        n_checks++;
        if (en_cnt != 0) begin n_errors++; $display("FAIL rel0_no_second_en: got %0d pulses expected 0", en_cnt); end
        n_checks++;
        if (first_chg != 3 + DEB) begin n_errors++; $display("FAIL rel0_resume: got %0d cycles expected %0d", first_chg, 3 + DEB); end
    endtask

    task automatic test_two_keys();
        int en_cnt = 0;
        int lat = 0;
        bit seen = 0;
        pressed[3] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (en) begin seen = 1; en_cnt++; end
        end
        n_checks++;
        if (!seen || s !== 4'hA) begin n_errors++; $display("FAIL two_first: got seen=%0d s=%h expected en with s=A", seen, s); end
        pressed[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (en) en_cnt++;
        end
        n_checks++;
        if (en_cnt != 1 || s !== 4'hA) begin n_errors++; $display("FAIL two_ignored: got %0d pulses s=%h expected 1 pulse s=A", en_cnt, s); end
        pressed[3] = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n_checks++;
            if ({cols, s, en} !== {col_drive(m.col), m.s, m.en}) begin
                n_errors++;
                $display("FAIL two_model: got cols=%b s=%h en=%b expected cols=%b s=%h en=%b", cols, s, en, col_drive(m.col), m.s, m.en);
            end
            if (en) begin en_cnt++; if (lat == 0) lat = i; end
        end
        n_checks++;
        if (en_cnt != 2 || s !== 4'h1) begin n_errors++; $display("FAIL two_second: got %0d pulses s=%h expected 2 pulses s=1", en_cnt, s); end
        n_checks++;
        if (lat != 3 + 2 * DEB + SD) begin n_errors++; $display("FAIL two_latency: got %0d expected %0d", lat, 3 + 2 * DEB + SD); end
        pressed = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_held_d();
        int en_cnt = 0;
        bit seen = 0;
        pressed[15] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (en) seen = 1;
        end
        n_checks++;
        if (!seen || s !== 4'hD) begin n_errors++; $display("FAIL rstd_first: got seen=%0d s=%h expected en with s=D", seen, s); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cols, s, en} !== {4'b1110, 4'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL rstd_reset: got cols=%b s=%h en=%b expected cols=1110 s=0 en=0", cols, s, en);
        end
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_checks++;
            if ({cols, s, en} !== {col_drive(m.col), m.s, m.en}) begin
                n_errors++;
                $display("FAIL rstd_model: got cols=%b s=%h en=%b expected cols=%b s=%h en=%b", cols, s, en, col_drive(m.col), m.s, m.en);
            end
            if (en) en_cnt++;
        end
        n_checks++;
        if (en_cnt != 1 || s !== 4'hD) begin n_errors++; $display("FAIL rstd_fresh: got %0d pulses s=%h expected 1 pulse s=D", en_cnt, s); end
        pressed = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int         k;
            int         hold;
            int         idle;
            int         en_cnt;
            logic       prev_en;
            logic [3:0] prev_s;
            k = $urandom_range(0, 15);
            hold = $urandom_range(40, 70);
            idle = $urandom_range(20, 40);
            en_cnt = 0;
            prev_en = en;
            prev_s = s;
            pressed = '0;
            pressed[k] = 1'b1;
            for (int i = 0; i < hold + idle; i++) begin
                if (i == hold) pressed = '0;
                @(negedge clk);
                n_checks++;
                if ({cols, s, en} !== {col_drive(m.col), m.s, m.en}) begin
                    n_errors++;
                    $display("FAIL rand_model key %0d: got cols=%b s=%h en=%b expected cols=%b s=%h en=%b", k, cols, s, en, col_drive(m.col), m.s, m.en);
                end
                n_checks++;
                if ((en && prev_en) || (s !== prev_s && !en)) begin
                    n_errors++;
                    $display("FAIL rand_strobe key %0d: got en=%b prev_en=%b s=%h prev_s=%h expected single strobe with s change", k, en, prev_en, s, prev_s);
                end
                if (en) en_cnt++;
                prev_en = en;
                prev_s = s;
            end
            n_checks++;
            if (en_cnt != 1 || s !== key_digit(k)) begin
                n_errors++;
                $display("FAIL rand_press key %0d: got %0d pulses s=%h expected 1 pulse s=%h", k, en_cnt, s, key_digit(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press_5();
        test_bounce_9();
        test_release_bounce_0();
        test_two_keys();
        test_reset_held_d();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the columns of a 4x4 matrix keypad and reads its rows.
- Debounces both press and release of a key.
- For each accepted press, emits the hex digit `s` together with a single-cycle `en` strobe.
- It is the producer side of the digit interface that feeds the two-digit history memory and the dual seven-segment display path.

Parameters:
- SCAN_DIV, 4096, clock cycles each column is driven during scanning (>=4)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (>=2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rows  input  4  keypad rows, active-low, asynchronous (pulled up externally)
- cols  output  4  keypad column drive, active-low, exactly one bit low at all times
- s  output  4  digit of most recent accepted key, held until next accepted press
- en  output  1  one-cycle strobe: new digit on `s`

Behaviour:
- Reset: synchronous, active-high; `clk` is the only clock.
  - Reset values: cols=4'b1110, s=4'h0, en=0, state=SCAN, scan and debounce counters=0, synchronizer flops=4'b1111.
- Synchronizer: `rows` passes through a 2-flop synchronizer; `rsync` denotes its output. All decisions use `rsync` only.
- Key map (row r, column c, index 0 first):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Column index c drives cols bit c low.
- States:
  - SCAN:
    - Scan counter counts 0..SCAN_DIV-1.
    - Sample only when counter==SCAN_DIV-1, which allows settling.
    - If rsync != 4'b1111, latch r = lowest-index low row; latch c = current column; go DEBOUNCE with debounce counter=0. The column is not advanced.
    - Otherwise advance column c -> (c+1) mod 4, so the column order is 1110, 1101, 1011, 0111, 1110, … Counter wraps to 0.
  - DEBOUNCE:
    - Column c held.
    - Each cycle rsync[r]==0: counter++.
    - If counter reaches DEBOUNCE_CYCLES-1 with rsync[r]==0: go HELD, load s=map(r,c), and en=1 on the next cycle only.
    - Any cycle rsync[r]==1 (bounce): return to SCAN on the same column, scan counter=0, no en.
  - HELD:
    - Column c held.
    - While rsync[r]==0, stay.
    - On rsync[r]==1, go RELEASE with counter=0.
  - RELEASE:
    - Each cycle rsync[r]==1: counter++.
    - At DEBOUNCE_CYCLES-1: go SCAN, advance to column (c+1) mod 4, scan counter=0.
    - Any cycle rsync[r]==0: return to HELD. No new en.
- Latency: with detection sample at cycle T, en=1 at cycle T+DEBOUNCE_CYCLES+1, given rsync[r] low on cycles T+1..T+DEBOUNCE_CYCLES.
- en rules:
  - en is high for exactly one cycle per accepted press, never two consecutive cycles.
  - s changes only in the cycle en rises.
- Multiple keys:
  - Only key (r,c) is tracked once latched; other rows, and other columns' keys, are ignored until RELEASE completes.
  - Two keys in the same column at detection: lowest row wins.
- Held key: never produces repeat strobes; auto-repeat is not supported.
- Reset mid-operation:
  - Any state returns to SCAN at column 0, with s=0 and en=0.
  - A key still held after reset is detected afresh and produces one new en after full debounce.
- Counter widths: $clog2 of the respective parameter. Counters saturate/clear per state and never wrap within DEBOUNCE/RELEASE.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Reset then idle with rows=4'b1111 for 40 cycles -> cols cycles 1110,1101,1011,0111, each held 4 cycles; en never 1; s=0.
- Press key "5" (row1 low whenever cols==1101), held 100 cycles -> exactly one en pulse; s=4'h5 from that cycle; cols frozen at 1101 while held; scanning resumes at 1011 after 8 released cycles.
- Press "9" with bounce: row2 low 3 cycles, high 1, then low steady -> first attempt aborts with no en; a later scan detects it; one en with s=4'h9.
- Release bounce: after "0" is accepted, release row3 for 4 cycles, re-press for 2, then release steady -> no second en; scan resumes only after 8 consecutive high cycles.
- Hold "A" (r0,c3), then also press "1" (r0,c0) while A is held, release A, then keep 1 held -> en/s=4'hA first; s=4'h1 only after A's release debounce plus rescan plus debounce; two en pulses total.
- Assert reset during HELD on "D" while the key stays pressed -> s=0, cols=1110 after reset; a fresh en with s=4'hD follows once column 3 is rescanned and debounced.
